// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter and sequencer for the multicycle core.
// One 64-bit memory is shared between instruction fetch and load/store.
// A granted access runs ACCESS -> WAIT (MEM_LAT cycles) -> RESP. Misaligned data
// accesses never reach the memory. They go ACCESS -> RESP and complete with d_err.
//
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   if_req, if_addr                     fetch request, held until if_gnt
//   if_gnt, if_rvalid, if_rdata         fetch grant pulse, completion pulse, instruction word
//   d_req, d_we, d_funct3, d_addr,      data request and payload, held until d_gnt
//   d_wdata
//   d_gnt, d_rvalid, d_rdata, d_err     data grant, completion, byte-shifted load data,
//                                       misaligned flag
//   mem_req, mem_we, mem_addr, mem_be,  memory port; mem_req strobes once per access
//   mem_wdata, mem_rdata
//   busy, state_out                     status (IDLE 00, ACCESS 01, WAIT 10, RESP 11)
//
// Build option: define MEM_ARB_RR_EN to resolve simultaneous requests round-robin.
// Without it, data always wins.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StWait   = 2'b10,
        StResp   = 2'b11
    } state_e;

    state_e     state_q;
    logic       src_data_q;  // 1: current access belongs to the data requester
    logic       we_q;
    logic [2:0] off_q;       // byte offset used to align read data
    logic       err_q;
    logic [2:0] cnt_q;
`ifdef MEM_ARB_RR_EN
    logic       rr_fetch_q;  // 1: fetch wins the next tie
`endif

    logic       pick_data;
    logic       pick_any;
    logic       d_mis;
    logic [7:0] d_mask;

    // Only size bits of funct3 matter; fetch addresses are word-aligned by definition.
    logic unused_bits;
    assign unused_bits = ^{d_funct3[2], if_addr[1:0]};

    always_comb begin
        d_mis  = 1'b0;
        d_mask = 8'h01;
        unique case (d_funct3[1:0])
            2'b00: begin d_mask = 8'h01; d_mis = 1'b0;          end
            2'b01: begin d_mask = 8'h03; d_mis = d_addr[0];     end
            2'b10: begin d_mask = 8'h0F; d_mis = |d_addr[1:0];  end
            2'b11: begin d_mask = 8'hFF; d_mis = |d_addr[2:0];  end
            default: ;
        endcase
    end

    always_comb begin
        pick_any = if_req | d_req;
`ifdef MEM_ARB_RR_EN
        pick_data = d_req & (~if_req | ~rr_fetch_q);
`else
        pick_data = d_req;
`endif
    end

    assign state_out = state_q;
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            src_data_q <= 1'b0;
            we_q       <= 1'b0;
            off_q      <= 3'd0;
            err_q      <= 1'b0;
            cnt_q      <= 3'd0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= 32'd0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= 64'd0;
            d_err      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 64'd0;
            mem_be     <= 8'd0;
            mem_wdata  <= 64'd0;
`ifdef MEM_ARB_RR_EN
            rr_fetch_q <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; the payload outputs hold their last value.
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            mem_req   <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            unique case (state_q)
                StIdle, StResp: begin
                    if (pick_any) begin
                        state_q    <= StAccess;
                        src_data_q <= pick_data;
`ifdef MEM_ARB_RR_EN
                        rr_fetch_q <= pick_data;
`endif
                        if (pick_data) begin
                            d_gnt     <= 1'b1;
                            mem_req   <= ~d_mis;
                            mem_we    <= d_we;
                            mem_addr  <= {d_addr[63:3], 3'b000};
                            mem_be    <= d_mask << d_addr[2:0];
                            mem_wdata <= d_wdata << {d_addr[2:0], 3'b000};
                            we_q      <= d_we;
                            off_q     <= d_addr[2:0];
                            err_q     <= d_mis;
                        end else begin
                            if_gnt    <= 1'b1;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= {if_addr[63:3], 3'b000};
                            mem_be    <= 8'hFF;
                            mem_wdata <= 64'd0;
                            we_q      <= 1'b0;
                            off_q     <= {if_addr[2], 2'b00};
                            err_q     <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StAccess: begin
                    if (err_q) begin
                        // Misaligned: no memory cycle, complete at once with an error.
                        state_q  <= StResp;
                        d_rvalid <= 1'b1;
                        d_err    <= 1'b1;
                        d_rdata  <= 64'd0;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= 3'(MEM_LAT - 1);
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= StResp;
                        if (src_data_q) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= we_q ? 64'd0 : (mem_rdata >> {off_q, 3'b000});
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= off_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [2:0]  d_funct3 = '0;
    logic [63:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [63:0] d_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_be;
    logic [63:0] mem_rdata = '0;
    logic        busy;
    logic [1:0]  state_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .state_out(state_out)
    );

    logic [241:0] all_out;
    assign all_out = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err, mem_req,
                      mem_we, mem_addr, mem_be, mem_wdata, busy, state_out};

    // Observations collected by run_txn (cycle index k = edges after the request cycle).
    int          obs_gnt_k, obs_stray, obs_mreq_cnt, obs_rv_k, obs_rv_cnt;
    logic        obs_we, obs_err;
    logic [63:0] obs_addr, obs_wdata, obs_rdata;
    logic [7:0]  obs_be;
    logic [31:0] obs_irdata;

    // Drives one request from idle and records what the DUT does. The memory model
    // presents good data only in the last WAIT cycle of a fixed-latency access.
    task automatic run_txn(input bit is_data, input bit we, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] good);
        obs_gnt_k = -1; obs_stray = 0; obs_mreq_cnt = 0; obs_rv_k = -1; obs_rv_cnt = 0;
        obs_we = 1'bx; obs_err = 1'bx; obs_addr = 'x; obs_wdata = 'x; obs_rdata = 'x;
        obs_be = 'x; obs_irdata = 'x;
        mem_rdata = ~good;
        if (is_data) begin
            d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 1; k <= int'(L) + 6; k++) begin
            @(posedge clk); #1;
            if ((is_data ? d_gnt : if_gnt) && obs_gnt_k < 0) begin
                obs_gnt_k = k; d_req = 1'b0; if_req = 1'b0;
            end
            if (is_data ? (if_gnt | if_rvalid) : (d_gnt | d_rvalid)) obs_stray++;
            if (mem_req) begin
                obs_mreq_cnt++;
                obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
            end
            if (is_data ? d_rvalid : if_rvalid) begin
                if (obs_rv_k < 0) obs_rv_k = k;
                obs_rv_cnt++;
                obs_rdata = d_rdata; obs_irdata = if_rdata; obs_err = d_err;
            end
            mem_rdata = (k == int'(L) + 1) ? good : ~good;
        end
        d_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, want 0", all_out);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (state_out !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: got %b, want 00", state_out);
        end
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b mem_req=%b, want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_fetch();
        run_txn(1'b0, 1'b0, 3'd0, 64'h104, 64'd0, 64'hAAAA_BBBB_1234_5678);
        vectors++;
        if (obs_gnt_k !== 1) begin
            miscompares++; $display("FAIL fetch_gnt_cycle: got %0d, want 1", obs_gnt_k);
        end
        vectors++;
        if (obs_addr !== 64'h100 || obs_be !== 8'hFF || obs_we !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_mem: got addr=%h be=%h we=%b, want 100 ff 0",
                     obs_addr, obs_be, obs_we);
        end
        vectors++;
        if (obs_rv_k !== 4 || obs_rv_cnt !== 1) begin
            miscompares++;
            $display("FAIL fetch_rvalid: got k=%0d n=%0d, want 4 1", obs_rv_k, obs_rv_cnt);
        end
        vectors++;
        if (obs_irdata !== 32'hAAAA_BBBB) begin
            miscompares++; $display("FAIL fetch_rdata: got %h, want aaaabbbb", obs_irdata);
        end
    endtask

    task automatic test_store_byte();
        run_txn(1'b1, 1'b1, 3'd0, 64'h203, 64'h5A, 64'h0123_4567_89AB_CDEF);
        vectors++;
        if (obs_be !== 8'h08 || obs_wdata[31:24] !== 8'h5A || obs_we !== 1'b1) begin
            miscompares++;
            $display("FAIL store_mem: got be=%h wdata=%h we=%b, want 08 5a<<24 1",
                     obs_be, obs_wdata, obs_we);
        end
        vectors++;
        if (obs_rv_k !== 4 || obs_err !== 1'b0 || obs_rdata !== 64'd0) begin
            miscompares++;
            $display("FAIL store_resp: got k=%0d err=%b rdata=%h, want 4 0 0",
                     obs_rv_k, obs_err, obs_rdata);
        end
    endtask

    task automatic test_misaligned();
        run_txn(1'b1, 1'b0, 3'd2, 64'h206, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        vectors++;
        if (obs_gnt_k !== 1 || obs_mreq_cnt !== 0) begin
            miscompares++;
            $display("FAIL misal_access: got gnt_k=%0d mem_req=%0d, want 1 0",
                     obs_gnt_k, obs_mreq_cnt);
        end
        vectors++;
        if (obs_rv_k !== 2 || obs_err !== 1'b1 || obs_rdata !== 64'd0) begin
            miscompares++;
            $display("FAIL misal_resp: got k=%0d err=%b rdata=%h, want 2 1 0",
                     obs_rv_k, obs_err, obs_rdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit          is_data = 1'($urandom_range(0, 1));
            bit          we = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [63:0] addr = {$urandom, $urandom};
            logic [63:0] wdata = {$urandom, $urandom};
            logic [63:0] good = {$urandom, $urandom};
            int unsigned sz = 1 << f3[1:0];
            int unsigned off = int'(addr[2:0]);
            bit          mis = is_data && ((off % sz) != 0);
            logic [7:0]  e_be = is_data ? 8'(((1 << sz) - 1) << off) : 8'hFF;
            logic [63:0] e_wd = is_data ? (wdata << (8 * off)) : 64'd0;
            logic [63:0] e_rd = (mis || we) ? 64'd0 : (good >> (8 * off));
            logic [31:0] e_ird = addr[2] ? good[63:32] : good[31:0];
            int          e_rvk = mis ? 2 : int'(L) + 2;
            run_txn(is_data, we, f3, addr, wdata, good);
            vectors++;
            if (obs_gnt_k !== 1 || obs_stray !== 0) begin
                miscompares++;
                $display("FAIL rnd%0d_gnt: got k=%0d stray=%0d, want 1 0", n, obs_gnt_k, obs_stray);
            end
            vectors++;
            if (obs_mreq_cnt !== (mis ? 0 : 1)) begin
                miscompares++;
                $display("FAIL rnd%0d_memreq: got %0d, want %0d", n, obs_mreq_cnt, mis ? 0 : 1);
            end
            if (!mis) begin
                vectors++;
                if (obs_addr !== {addr[63:3], 3'b000} || obs_we !== we || obs_be !== e_be
                    || obs_wdata !== e_wd) begin
                    miscompares++;
                    $display("FAIL rnd%0d_mem: got a=%h we=%b be=%h wd=%h, want %h %b %h %h", n,
                             obs_addr, obs_we, obs_be, obs_wdata, {addr[63:3], 3'b000}, we,
                             e_be, e_wd);
                end
            end
            vectors++;
            if (obs_rv_k !== e_rvk || obs_rv_cnt !== 1) begin
                miscompares++;
                $display("FAIL rnd%0d_rvalid: got k=%0d n=%0d, want %0d 1", n, obs_rv_k,
                         obs_rv_cnt, e_rvk);
            end
            vectors++;
            if (is_data && (obs_rdata !== e_rd || obs_err !== mis)) begin
                miscompares++;
                $display("FAIL rnd%0d_drdata: got %h err=%b, want %h %b", n, obs_rdata, obs_err,
                         e_rd, mis);
            end else if (!is_data && obs_irdata !== e_ird) begin
                miscompares++;
                $display("FAIL rnd%0d_irdata: got %h, want %h", n, obs_irdata, e_ird);
            end
        end
    endtask

    // Both requesters ask together; data then immediately issues a new access so the
    // second arbitration point also sees both requests.
    task automatic test_contention();
        int gk[3];
        bit gd[3];
        int ng = 0;
        int both = 0;
`ifdef MEM_ARB_RR_EN
        bit exp2_data = 1'b0;
`else
        bit exp2_data = 1'b1;
`endif
        reset = 1'b1; #2; reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin gk[i] = -1; gd[i] = 1'b0; end
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd3; d_addr = 64'h1000; d_wdata = '0;
        if_req = 1'b1; if_addr = 64'h2000;
        for (int k = 1; k <= 3 * (int'(L) + 2) + 4; k++) begin
            @(posedge clk); #1;
            mem_rdata = {$urandom, $urandom};
            if (d_gnt && if_gnt) both++;
            if ((d_gnt || if_gnt) && ng < 3) begin
                gk[ng] = k; gd[ng] = d_gnt; ng++;
                if (ng == 1) d_addr = 64'h1008;
                else if (ng == 2) begin
                    if (d_gnt) d_req = 1'b0; else if_req = 1'b0;
                end else begin
                    d_req = 1'b0; if_req = 1'b0;
                end
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        vectors++;
        if (both !== 0) begin
            miscompares++; $display("FAIL cont_dual_gnt: got %0d, want 0", both);
        end
        vectors++;
        if (gk[0] !== 1 || gd[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL cont_first: got k=%0d data=%b, want 1 1", gk[0], gd[0]);
        end
        vectors++;
        if (gk[1] !== int'(L) + 3 || gd[1] !== exp2_data) begin
            miscompares++;
            $display("FAIL cont_second: got k=%0d data=%b, want %0d %b", gk[1], gd[1],
                     int'(L) + 3, exp2_data);
        end
        vectors++;
        if (gk[2] !== 2 * int'(L) + 5 || gd[2] !== ~exp2_data) begin
            miscompares++;
            $display("FAIL cont_third: got k=%0d data=%b, want %0d %b", gk[2], gd[2],
                     2 * int'(L) + 5, ~exp2_data);
        end
    endtask

    task automatic test_reset_mid();
        int rv = 0;
        int mr = 0;
        if_req = 1'b1; if_addr = 64'h3000;
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (state_out !== 2'b10 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got state=%b busy=%b, want 10 1", state_out, busy);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++; $display("FAIL rstmid_async: got %h, want 0", all_out);
        end
        #1 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (if_rvalid || d_rvalid) rv++;
            if (mem_req) mr++;
        end
        vectors++;
        if (rv !== 0 || mr !== 0 || state_out !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_after: got rvalid=%0d mem_req=%0d state=%b, want 0 0 00",
                     rv, mr, state_out);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_byte();
        test_misaligned();
        test_random();
        test_contention();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer for the multicycle RISC-V core. It shares one 64-bit memory between the instruction-fetch requester and the load/store requester. Each granted access runs through a fixed-latency memory transaction, and the block generates byte enables and write-lane alignment from funct3/address. It sits between the datapath (PC/instruction register side and ALUOut/B side) and the memory model.

## Interface
- MEM_LAT, 2: cycles from the accepted mem_req to valid mem_rdata; legal range 1..7.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  64  fetch byte address; bits [1:0] ignored.
- if_gnt  out  1  one-cycle grant pulse to fetch.
- if_rvalid  out  1  one-cycle fetch completion.
- if_rdata  out  32  instruction word, selected by if_addr[2].
- d_req  in  1  data request; held with payload until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  size in [1:0]: 00 byte, 01 half, 10 word, 11 double.
- d_addr  in  64  data byte address.
- d_wdata  in  64  store data, right-aligned.
- d_gnt  out  1  one-cycle grant pulse to data.
- d_rvalid  out  1  one-cycle data completion (loads and stores).
- d_rdata  out  64  raw load data shifted so the addressed byte is in [7:0]; sign/zero extension is done in the datapath.
- d_err  out  1  misaligned access flag, valid with d_rvalid.
- mem_req  out  1  memory strobe, exactly one cycle per access.
- mem_we  out  1  memory write.
- mem_addr  out  64  doubleword address, {addr[63:3],3'b000}.
- mem_be  out  8  byte enables.
- mem_wdata  out  64  store data shifted left by addr[2:0]*8.
- mem_rdata  in  64  memory read data.
- busy  out  1  1 whenever state != IDLE.
- state_out  out  2  IDLE 00, ACCESS 01, WAIT 10, RESP 11.

## Operation
- FSM: IDLE → ACCESS → WAIT (MEM_LAT cycles) → RESP → IDLE; RESP also arbitrates (see Timing).
- Arbitration is sampled in IDLE and RESP. The winner's payload (addr, we, funct3, wdata) and source are registered. Next state is ACCESS.
- Default priority: data beats fetch.
- ACCESS: the winner's gnt is 1 and mem_req is 1. mem_we, mem_addr, mem_be and mem_wdata come from the registered payload. Fetch is always a read with mem_be = 8'hFF.
- mem_be: size mask 8'h01/8'h03/8'h0F/8'hFF shifted left by addr[2:0].
- Misaligned access: byte accesses are never misaligned. Half is misaligned when addr[0]=1, word when addr[1:0]!=0, double when addr[2:0]!=0.
  - ACCESS still pulses d_gnt, but mem_req stays 0.
  - Next state is RESP with d_err=1 and d_rdata=0. WAIT is skipped.
- WAIT: a 3-bit counter loads MEM_LAT-1 on entry and decrements. On the last WAIT edge, mem_rdata is registered (word or lane shifted).
- RESP: the source's rvalid is 1 for exactly one cycle. rdata holds until the next capture. Store completions report d_rdata = 0.
- if_err does not exist; fetch addresses are always treated as word-aligned.

## Timing
- Request sampled at the edge ending cycle N; ACCESS in N+1 (gnt, mem_req); WAIT in N+2..N+1+MEM_LAT; RESP/rvalid in N+2+MEM_LAT.
- Misaligned data access: ACCESS N+1, RESP N+2.
- Throughput: one access per MEM_LAT+2 cycles back-to-back. A request sampled during RESP goes directly to ACCESS.
- Requesters deassert req in the cycle after gnt unless issuing a new access. req is not sampled in ACCESS or WAIT.
- Simultaneous if_req and d_req: only the winner is granted. The loser keeps req high and is sampled again at the next IDLE/RESP.
- Reset state: IDLE, all outputs 0, the RR pointer favors data, and the capture registers are cleared.
- Reset mid-access forces mem_req=0 and IDLE immediately (asynchronous). The in-flight request is dropped and no rvalid is issued.

## Configuration
- MEM_ARB_RR_EN defined:
  - When both requests are sampled together, the requester not served last wins.
  - The pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed data priority; no pointer register.

## Test plan
- Fetch only, MEM_LAT=2, if_addr=0x104, mem_rdata=0xAAAA_BBBB_1234_5678 in WAIT:
  - if_gnt at N+1, mem_addr=0x100.
  - if_rvalid at N+4 with if_rdata=0xAAAA_BBBB.
- Store byte at d_addr=0x203, d_wdata=0x5A:
  - mem_be=8'h08, mem_wdata[31:24]=0x5A, mem_we=1.
  - d_rvalid at N+4 with d_err=0.
- Load word at d_addr=0x206:
  - d_gnt at N+1, mem_req stays 0.
  - d_rvalid and d_err=1 at N+2.
- if_req and d_req asserted together twice in succession:
  - Without the macro, data is granted both times.
  - With MEM_ARB_RR_EN, data is granted first, then fetch.
- Reset asserted during WAIT:
  - All outputs go to 0 and state_out=00 without waiting for a clock edge.
  - No rvalid is seen after reset releases.
